mode_scheduler: RTL

MODE_SCHEDULER -- requirements
Module: mode_scheduler

---
 rtl/mode_scheduler_if.sv | 31 +++
 rtl/mode_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mode_scheduler_if.sv
// Signal bundle between mode_scheduler, its push-buttons and the three music sources.
interface mode_scheduler_if;
   logic       mode_btn;
   logic       next_btn;
   logic       prev_btn;
   logic       auto_done;
   logic       spk_free;
   logic       spk_auto;
   logic       spk_learn;
   logic [6:0] led_free;
   logic [6:0] led_auto;
   logic [6:0] led_learn;
   logic [1:0] mode;
   logic       speaker;
   logic [6:0] led;
   logic [2:0] sub_reset;
   logic       next_pulse;
   logic       prev_pulse;

   modport master (
      output mode_btn, next_btn, prev_btn, auto_done,
      output spk_free, spk_auto, spk_learn, led_free, led_auto, led_learn,
      input  mode, speaker, led, sub_reset, next_pulse, prev_pulse
   );

   modport slave (
      input  mode_btn, next_btn, prev_btn, auto_done,
      input  spk_free, spk_auto, spk_learn, led_free, led_auto, led_learn,
      output mode, speaker, led, sub_reset, next_pulse, prev_pulse
   );
endinterface

// File: rtl/mode_scheduler.sv
// Mode scheduler: debounced buttons step FREE->AUTO->LEARN and arbitrate speaker/LEDs.
// Optional silent MUTE gap between modes is enabled by defining MODE_MUTE_GAP_EN.
module mode_scheduler #(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned MUTE_CYCLES     = 16
) (
   input logic             clk,
   input logic             reset,
   mode_scheduler_if.slave bus
);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned MC_W = $clog2(MUTE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      AUTO  = 2'd1,
      LEARN = 2'd2,
      MUTE  = 2'd3
   } state_t;

   function automatic logic [2:0] onehot(input state_t s);
      case (s)
         FREE:    return 3'b001;
         AUTO:    return 3'b010;
         LEARN:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // bit0 mode, bit1 next, bit2 prev
   logic [2:0]      btn_raw;
   logic [2:0]      sync_p0;
   logic [2:0]      sync_p1;
   logic [2:0]      db_level;
   logic [2:0]      press;
   logic [DB_W-1:0] db_cnt [3];

   state_t          state_r, state_nx;
   state_t          target_r, target_nx;
   state_t          tgt;
   logic            trig;
   logic [MC_W-1:0] mute_cnt, mute_cnt_nx;

   logic            speaker_r, speaker_nx;
   logic [6:0]      led_r, led_nx;
   logic [2:0]      sub_reset_r, sub_reset_nx;
   logic            next_pulse_r, next_pulse_nx;
   logic            prev_pulse_r, prev_pulse_nx;

   assign btn_raw = {bus.prev_btn, bus.next_btn, bus.mode_btn};

   // Synchronizer (p0, p1) and debouncer; press fires only on an accepted 0->1 level change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         db_level <= '0;
         press    <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
         for (int i = 0; i < 3; i++) begin
            press[i] <= 1'b0;
            if (sync_p1[i] != db_level[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  db_level[i] <= sync_p1[i];
                  db_cnt[i]   <= '0;
                  press[i]    <= sync_p1[i];
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= FREE;
         target_r     <= FREE;
         mute_cnt     <= '0;
         speaker_r    <= 1'b0;
         led_r        <= '0;
         sub_reset_r  <= 3'b001;
         next_pulse_r <= 1'b0;
         prev_pulse_r <= 1'b0;
      end else begin
         state_r      <= state_nx;
         target_r     <= target_nx;
         mute_cnt     <= mute_cnt_nx;
         speaker_r    <= speaker_nx;
         led_r        <= led_nx;
         sub_reset_r  <= sub_reset_nx;
         next_pulse_r <= next_pulse_nx;
         prev_pulse_r <= prev_pulse_nx;
      end
   end

   // Next-state logic; a mode press outranks auto_done in AUTO, and MUTE ignores all triggers.
   always_comb begin
      state_nx    = state_r;
      target_nx   = target_r;
      mute_cnt_nx = mute_cnt;
      trig        = 1'b0;
      tgt         = FREE;
      case (state_r)
         FREE: begin
            if (press[0]) begin
               trig = 1'b1;
               tgt  = AUTO;
            end
         end
         AUTO: begin
            if (press[0]) begin
               trig = 1'b1;
               tgt  = LEARN;
            end else if (bus.auto_done) begin
               trig = 1'b1;
               tgt  = FREE;
            end
         end
         LEARN: begin
            if (press[0]) begin
               trig = 1'b1;
               tgt  = FREE;
            end
         end
         default: ;
      endcase
      if (state_r == MUTE) begin
         if (mute_cnt <= MC_W'(1)) begin
            state_nx    = target_r;
            mute_cnt_nx = '0;
         end else begin
            mute_cnt_nx = mute_cnt - 1'b1;
         end
      end else if (trig) begin
`ifdef MODE_MUTE_GAP_EN
         state_nx    = MUTE;
         target_nx   = tgt;
         mute_cnt_nx = MC_W'(MUTE_CYCLES);
`else
         state_nx    = tgt;
         target_nx   = tgt;
`endif
      end
   end

   // Output logic; selection follows the state being entered so MUTE is silent from its first cycle.
   always_comb begin
      speaker_nx = 1'b0;
      led_nx     = '0;
      case (state_nx)
         FREE: begin
            speaker_nx = bus.spk_free;
            led_nx     = bus.led_free;
         end
         AUTO: begin
            speaker_nx = bus.spk_auto;
            led_nx     = bus.led_auto;
         end
         LEARN: begin
            speaker_nx = bus.spk_learn;
            led_nx     = bus.led_learn;
         end
         default: ;
      endcase
      if (state_nx == MUTE)
         sub_reset_nx = onehot(target_nx);
      else if (state_nx != state_r && state_r != MUTE)
         sub_reset_nx = onehot(state_nx);
      else
         sub_reset_nx = 3'b000;
      next_pulse_nx = press[1] & ~press[2] & ((state_r == AUTO) || (state_r == LEARN));
      prev_pulse_nx = press[2] & ~press[1] & ((state_r == AUTO) || (state_r == LEARN));
   end

   assign bus.mode       = state_r;
   assign bus.speaker    = speaker_r;
   assign bus.led        = led_r;
   assign bus.sub_reset  = sub_reset_r;
   assign bus.next_pulse = next_pulse_r;
   assign bus.prev_pulse = prev_pulse_r;
endmodule
